dot_product_sequencer: RTL

- Drives the 16-bit sequential multiplier's start/done handshake. Accepts a stream of operand pairs, feeds them to the multiplier one at a time, and accumulates the 16-bit products into a wide sum.
- Sits upstream and downstream of the multiplier at once: it feeds the operands and consumes the products.
- Emits one result per vector; a vector is delimited by in_last.

---
 rtl/dps_pkg.sv | 19 +
 rtl/dps_operand_fifo.sv | 54 +++++
 rtl/dot_product_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/dps_pkg.sv
// Shared types for the dot-product sequencer: FSM states, the buffered
// operand pair and the operand width used by the attached multiplier.
package dps_pkg;

  localparam int OPW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    OUTPUT = 2'd2
  } dps_state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           last;
  } operand_pair_t;

endpackage

// File: rtl/dps_operand_fifo.sv
// Small synchronous FIFO buffering operand pairs ahead of the multiplier.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dps_operand_fifo
  import dps_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  operand_pair_t push_data,
  input  logic          pop,
  output operand_pair_t pop_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  operand_pair_t mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers; push and pop in the same cycle are both honoured.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; only control state is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are meaningless until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dot_product_sequencer.sv
// Feeds buffered operand pairs to a 16-bit sequential multiplier through its
// start/done handshake and accumulates the products into one result per
// vector (a vector ends at the pair flagged in_last).
module dot_product_sequencer
  import dps_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 24,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [OPW-1:0]   mul_a,
  output logic [OPW-1:0]   mul_b,
  input  logic [OPW-1:0]   mul_product,
  input  logic             mul_done,
  input  logic             mul_bsy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_sum,
  output logic [CNT_W-1:0] res_count,
  output logic             res_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  operand_pair_t    push_data, head;
  logic             fifo_full, fifo_empty, issue;
  dps_state_t       state_q, state_d;
  logic [OPW-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   acc_sum;

  assign push_data = {in_a, in_b, in_last};
  assign in_ready  = !fifo_full;

  // bsy is only a gate for issuing; completion is detected from done alone.
  assign issue = (state_q == IDLE) && !fifo_empty && !mul_bsy;

  dps_operand_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data (push_data),
    .pop       (issue),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Product is already truncated to 16 bits; extend with zeros, keep carry.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(mul_product);

  // Next-state and datapath update for the issue / wait / output sequence.
  always_comb begin
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    last_d  = last_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          mul_a_d = head.a;
          mul_b_d = head.b;
          last_d  = head.last;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mul_done) begin
          acc_d   = acc_sum[ACC_W-1:0];
          ovf_d   = ovf_q | acc_sum[ACC_W];
          cnt_d   = cnt_q + CNT_ONE;
          state_d = last_q ? OUTPUT : IDLE;
        end
      end
      OUTPUT: begin
        if (res_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand hold and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mul_a_q <= '0;
      mul_b_q <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operands come straight from the FIFO head in the issue cycle, then hold.
  assign mul_start = issue;
  assign mul_a     = issue ? head.a : mul_a_q;
  assign mul_b     = issue ? head.b : mul_b_q;

  assign res_valid = (state_q == OUTPUT);
  assign res_sum   = acc_q;
  assign res_count = cnt_q;
  assign res_ovf   = ovf_q;

endmodule
